// File: rtl/ascon_perm_iter_if.sv
// Request/result bundle between the mode controller and the ASCON permutation core.
// The controller drives start/rounds/state_in; the core answers with ready/out_valid/bad_rounds/state_out.
interface ascon_perm_iter_if;
  logic         start;
  logic [4:0]   rounds;
  logic [319:0] state_in;
  logic         ready;
  logic         out_valid;
  logic         bad_rounds;
  logic [319:0] state_out;

  modport master (
    output start, rounds, state_in,
    input  ready, out_valid, bad_rounds, state_out
  );

  modport slave (
    input  start, rounds, state_in,
    output ready, out_valid, bad_rounds, state_out
  );
endinterface

// File: rtl/ascon_perm_iter.sv
// Iterative ASCON p^6/p^8/p^12, one round per clock; result pulses rounds+1 cycles after acceptance.
// start is taken only while ready=1 (IDLE); no queuing, requests during RUN are dropped.
module ascon_perm_iter (
  input  logic             clk,
  input  logic             rst_n,
  ascon_perm_iter_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} fsm_t;

  fsm_t         r_fsm, w_fsm_nxt;
  logic [3:0]   r_ctr, w_ctr_nxt;
  logic [4:0]   r_rounds, w_rounds_nxt;
  logic [319:0] r_x, w_x_nxt;
  logic         r_out_valid, w_out_valid_nxt;
  logic         r_bad, w_bad_nxt;

  logic [3:0]   w_k;
  logic [7:0]   w_rc;
  logic         w_legal;
  logic [63:0]  w_a [5];
  logic [63:0]  w_t [5];
  logic [63:0]  w_b [5];
  logic [63:0]  w_s [5];
  logic [319:0] w_round;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Constant index only depends on latched rounds, so p^6/p^8 run the tail of the p^12 schedule.
  assign w_k     = 4'd11 - r_rounds[3:0] + r_ctr;
  assign w_rc    = {~w_k, w_k};
  assign w_legal = (bus.rounds == 5'd6) || (bus.rounds == 5'd8) || (bus.rounds == 5'd12);

  always_comb begin
    w_a[0] = r_x[319:256] ^ r_x[63:0];
    w_a[1] = r_x[255:192];
    w_a[2] = r_x[191:128] ^ {56'h0, w_rc} ^ r_x[255:192];
    w_a[3] = r_x[127:64];
    w_a[4] = r_x[63:0] ^ r_x[127:64];
    for (int i = 0; i < 5; i++) begin
      w_t[i] = ~w_a[i] & w_a[(i + 1) % 5];
    end
    for (int i = 0; i < 5; i++) begin
      w_b[i] = w_a[i] ^ w_t[(i + 1) % 5];
    end
    w_s[0] = w_b[0] ^ w_b[4];
    w_s[1] = w_b[1] ^ w_b[0];
    w_s[2] = ~w_b[2];
    w_s[3] = w_b[3] ^ w_b[2];
    w_s[4] = w_b[4];
    w_round = {w_s[0] ^ ror64(w_s[0], 19) ^ ror64(w_s[0], 28),
               w_s[1] ^ ror64(w_s[1], 61) ^ ror64(w_s[1], 39),
               w_s[2] ^ ror64(w_s[2], 1)  ^ ror64(w_s[2], 6),
               w_s[3] ^ ror64(w_s[3], 10) ^ ror64(w_s[3], 17),
               w_s[4] ^ ror64(w_s[4], 7)  ^ ror64(w_s[4], 41)};
  end

  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_ctr_nxt       = r_ctr;
    w_rounds_nxt    = r_rounds;
    w_x_nxt         = r_x;
    w_out_valid_nxt = 1'b0;
    w_bad_nxt       = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (bus.start) begin
          w_x_nxt      = bus.state_in;
          w_rounds_nxt = bus.rounds;
          w_ctr_nxt    = 4'd1;
          if (w_legal) begin
            w_fsm_nxt = S_RUN;
          end else begin
            w_out_valid_nxt = 1'b1;
            w_bad_nxt       = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_x_nxt   = w_round;
        w_ctr_nxt = r_ctr + 4'd1;
        if ({1'b0, r_ctr} == r_rounds) begin
          w_fsm_nxt       = S_IDLE;
          w_out_valid_nxt = 1'b1;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_ctr       <= 4'd0;
      r_rounds    <= 5'd0;
      r_x         <= 320'h0;
      r_out_valid <= 1'b0;
      r_bad       <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_ctr       <= w_ctr_nxt;
      r_rounds    <= w_rounds_nxt;
      r_x         <= w_x_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_bad       <= w_bad_nxt;
    end
  end

  assign bus.ready      = (r_fsm == S_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.bad_rounds = r_bad;
  assign bus.state_out  = r_x;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: table-driven S-box reference, per-cycle compare against a countdown model.
module tb_ascon_perm_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ascon_perm_iter_if bus();

  ascon_perm_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // 5-bit ASCON S-box, input/output index = {x0,x1,x2,x3,x4} of one bit column.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] sbox_layer(input logic [319:0] s);
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    for (int i = 0; i < 5; i++) y[i] = 64'h0;
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < 5; i++) col[4 - i] = s[319 - 64 * i - 63 + j];
      o = SBOX[col];
      for (int i = 0; i < 5; i++) y[i][j] = o[4 - i];
    end
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] lin_layer(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    {x0, x1, x2, x3, x4} = s;
    return {x0 ^ rotr(x0, 19) ^ rotr(x0, 28), x1 ^ rotr(x1, 61) ^ rotr(x1, 39),
            x2 ^ rotr(x2, 1)  ^ rotr(x2, 6),  x3 ^ rotr(x3, 10) ^ rotr(x3, 17),
            x4 ^ rotr(x4, 7)  ^ rotr(x4, 41)};
  endfunction

  // Constant for 0-based round idx of p^r: 0xf0 stepping down by 0x0f.
  function automatic logic [7:0] rc_of(input int r, input int idx);
    int k;
    k = 12 - r + idx;
    return 8'(240 - 15 * k);
  endfunction

  function automatic logic [319:0] perm_ref(input logic [319:0] s_in, input int r);
    logic [319:0] s;
    s = s_in;
    for (int i = 0; i < r; i++) begin
      s[135:128] = s[135:128] ^ rc_of(r, i);
      s = lin_layer(sbox_layer(s));
    end
    return s;
  endfunction

  function automatic bit legal(input logic [4:0] r);
    return (r == 5'd6) || (r == 5'd8) || (r == 5'd12);
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[32 * k +: 32] = $urandom;
    return v;
  endfunction

  // Cycle model: a request occupies the core for 'rounds' edges, then the result pulses.
  bit           m_init = 1'b0;
  int           m_busy = 0;
  int           m_rounds = 0;
  bit           m_ov = 1'b0;
  bit           m_bad = 1'b0;
  logic [319:0] m_out = '0;
  logic [319:0] m_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1'b1;
      m_busy = 0;
      m_ov   = 1'b0;
      m_bad  = 1'b0;
      m_out  = '0;
    end else if (m_init) begin
      m_ov  = 1'b0;
      m_bad = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ov  = 1'b1;
          m_out = m_res;
        end
      end else if (bus.start) begin
        m_rounds = int'(bus.rounds);
        if (legal(bus.rounds)) begin
          m_busy = m_rounds;
          m_res  = perm_ref(bus.state_in, m_rounds);
        end else begin
          m_ov  = 1'b1;
          m_bad = 1'b1;
          m_out = bus.state_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("ready", 320'(bus.ready), 320'(m_busy == 0));
      chk("out_valid", 320'(bus.out_valid), 320'(m_ov));
      chk("bad_rounds", 320'(bus.bad_rounds), 320'(m_bad));
      if (m_busy == 0) chk("state_out", bus.state_out, m_out);
      else chk("round_const", 320'(dut.w_rc), 320'(rc_of(m_rounds, m_rounds - m_busy)));
    end
  end

  task automatic wait_ov(inout int n);
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.rounds   = 5'($urandom);
      bus.state_in = rand320();
    end
  endtask

  // Called at a negedge; returns at the negedge inside the out_valid cycle.
  task automatic do_req(input logic [4:0] r, input logic [319:0] s, input int exp_lat);
    int n;
    bus.start    = 1'b1;
    bus.rounds   = r;
    bus.state_in = s;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ov(n);
    chk("latency", 320'(n), 320'(exp_lat));
  endtask

  initial begin
    logic [319:0] iv;
    logic [319:0] s0;
    logic [319:0] s1;
    logic [4:0]   r;
    int           n;
    int           sel;

    // Pin the reference model with hand-derived values.
    chk("pin_rc12", 320'(rc_of(12, 0)), 320'(8'hf0));
    chk("pin_rc12_2", 320'(rc_of(12, 1)), 320'(8'he1));
    chk("pin_rc8", 320'(rc_of(8, 0)), 320'(8'hb4));
    chk("pin_rc6", 320'(rc_of(6, 0)), 320'(8'h96));
    chk("pin_rc_end", 320'(rc_of(6, 5)), 320'(8'h4b));
    chk("pin_sbox0", sbox_layer(320'h0), {128'h0, 64'hffff_ffff_ffff_ffff, 128'h0});
    chk("pin_sbox1", sbox_layer(320'h1),
        {64'h0, 64'h1, 64'hffff_ffff_ffff_fffe, 64'h1, 64'h1});
    chk("pin_lin_x0", lin_layer({64'h1, 256'h0}), {64'h0000_2010_0000_0001, 256'h0});
    chk("pin_lin_x1", lin_layer({64'h0, 64'h1, 192'h0}),
        {64'h0, 64'h0000_0000_0200_0009, 192'h0});

    iv = {64'h8040_0c06_0000_0000, 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f,
          128'h1011_1213_1415_1617_1819_1a1b_1c1d_1e1f};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.rounds   = 5'd0;
    bus.state_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    do_req(5'd12, 320'h0, 13);
    chk("p12_zero", bus.state_out, perm_ref(320'h0, 12));

    repeat (2) @(negedge clk);
    do_req(5'd6, iv, 7);
    chk("p6_iv", bus.state_out, perm_ref(iv, 6));
    do_req(5'd8, iv, 9);
    chk("p8_iv_b2b", bus.state_out, perm_ref(iv, 8));

    @(negedge clk);
    s0 = rand320();
    do_req(5'd7, s0, 1);
    chk("bad7_state", bus.state_out, s0);
    chk("bad7_flag", 320'(bus.bad_rounds), 320'(1));
    chk("bad7_ready", 320'(bus.ready), 320'(1));
    s0 = rand320();
    do_req(5'd0, s0, 1);
    chk("bad0_state", bus.state_out, s0);

    // A start pulse during RUN must be dropped.
    @(negedge clk);
    s0 = rand320();
    s1 = rand320();
    bus.start    = 1'b1;
    bus.rounds   = 5'd12;
    bus.state_in = s0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start    = 1'b1;
    bus.rounds   = 5'd6;
    bus.state_in = s1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 4;
    wait_ov(n);
    chk("ignored_start_lat", 320'(n), 320'(13));
    chk("ignored_start_res", bus.state_out, perm_ref(s0, 12));

    // Reset sampled at the edge of round 5 of p^8.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.rounds   = 5'd8;
    bus.state_in = iv;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 320'(bus.ready), 320'(1));
    chk("rst_ov", 320'(bus.out_valid), 320'(0));
    chk("rst_state", bus.state_out, 320'h0);
    repeat (12) @(negedge clk);
    s0 = rand320();
    do_req(5'd6, s0, 7);
    chk("after_rst_p6", bus.state_out, perm_ref(s0, 6));

    for (int it = 0; it < 24; it++) begin
      s0  = rand320();
      sel = $urandom_range(0, 9);
      r   = (sel < 3) ? 5'd6 : (sel < 6) ? 5'd8 : (sel < 9) ? 5'd12 : 5'($urandom_range(0, 31));
      do_req(r, s0, legal(r) ? int'(r) + 1 : 1);
      chk("rand_result", bus.state_out, legal(r) ? perm_ref(s0, int'(r)) : s0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
